mem_stage: RTL and testbench



---
 rtl/mem_stage_pkg.sv | 44 ++++
 rtl/mem_stage_if.sv | 27 ++
 rtl/mem_load_align.sv | 14 +
 rtl/mem_stage.sv | 156 +++++++++++++++
 tb/tb_mem_stage.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: load-op bit positions,
// the writeback payload layout and the load byte/half extraction helper.
package mem_stage_pkg;

   // Bit positions inside the one-hot {ld_b, ld_bu, ld_h, ld_hu, ld_w} field
   localparam int LD_B  = 4;
   localparam int LD_BU = 3;
   localparam int LD_H  = 2;
   localparam int LD_HU = 1;
   localparam int LD_W  = 0;

   // pc + rf_we + rf_waddr + rf_wdata + ex
   localparam int MS2WS_BUS_WD = 32 + 1 + 5 + 32 + 1;

   typedef struct packed {
      logic [31:0] pc;
      logic        rf_we;
      logic [4:0]  rf_waddr;
      logic [31:0] rf_wdata;
      logic        ex;
   } ms2ws_bus_t;

   // Select the addressed byte or halfword of w and extend it to 32 bits.
   // A zero ld_op falls back to the full word.
   function automatic logic [31:0] load_extend(input logic [31:0] w,
                                               input logic [1:0]  a,
                                               input logic [4:0]  ld_op);
      logic [7:0]  b;
      logic [15:0] h;
      b = 8'(w >> {a, 3'b000});
      h = a[1] ? w[31:16] : w[15:0];
      if (ld_op[LD_B])
         load_extend = {{24{b[7]}}, b};
      else if (ld_op[LD_BU])
         load_extend = {24'h0, b};
      else if (ld_op[LD_H])
         load_extend = {{16{h[15]}}, h};
      else if (ld_op[LD_HU])
         load_extend = {16'h0, h};
      else
         load_extend = w;
   endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Execute-to-memory handshake bundle: valid/allowin plus the instruction fields.
interface mem_stage_if;
   logic        es2ms_valid;
   logic        ms_allowin;
   logic [31:0] es_pc;
   logic        es_mem_req;
   logic        es_res_from_mem;
   logic [4:0]  es_ld_op;
   logic        es_rf_we;
   logic [4:0]  es_rf_waddr;
   logic [31:0] es_result;
   logic        es_ex;

   // Execute stage side
   modport master (
      output es2ms_valid, es_pc, es_mem_req, es_res_from_mem, es_ld_op,
             es_rf_we, es_rf_waddr, es_result, es_ex,
      input  ms_allowin
   );

   // Memory stage side
   modport slave (
      input  es2ms_valid, es_pc, es_mem_req, es_res_from_mem, es_ld_op,
             es_rf_we, es_rf_waddr, es_result, es_ex,
      output ms_allowin
   );
endinterface

// File: rtl/mem_load_align.sv
// Combinational load alignment: picks the addressed byte/half and extends it.
module mem_load_align
   import mem_stage_pkg::*;
(
   input  logic [31:0] w,
   input  logic [1:0]  a,
   input  logic [4:0]  ld_op,
   output logic [31:0] data
);

   // The extraction rules live in the package so every user agrees on them
   assign data = load_extend(w, a, ld_op);

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: holds one instruction, waits for its data-SRAM
// response, buffers it across writeback back-pressure, and drops responses
// belonging to requests cancelled by a writeback flush.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 2
)
(
   input  logic        clk,
   input  logic        resetn,
   mem_stage_if.slave  es,
   input  logic        data_sram_data_ok,
   input  logic [31:0] data_sram_rdata,
   input  logic        ws_allowin,
   input  logic        wb_ex,
   output logic        ms2ws_valid,
   output logic [31:0] ms_pc,
   output logic        ms_rf_we,
   output logic [4:0]  ms_rf_waddr,
   output logic [31:0] ms_rf_wdata,
   output logic        ms_ex,
   output logic        ms_fwd_blk
);

   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam int SUM_W = CNT_W + 2;

   logic                    ms_valid;
   logic [31:0]             pc_r;
   logic [31:0]             result_r;
   logic                    mem_req_r;
   logic                    res_from_mem_r;
   logic                    rf_we_r;
   logic                    ex_r;
   logic [4:0]              ld_op_r;
   logic [4:0]              rf_waddr_r;
   logic [31:0]             rdata_buf;
   logic                    rdata_buf_valid;
   logic [CNT_W-1:0]        discard_cnt;
   logic [CNT_W-1:0]        discard_cnt_next;
   logic [SUM_W-1:0]        cnt_sum;
   logic                    cnt_zero;
   logic                    wait_mem;
   logic                    data_ready;
   logic                    ms_ready_go;
   logic                    ms_leave;
   logic                    capture_rdata;
   logic                    inc_flushed_ms;
   logic                    inc_flushed_es;
   logic                    dec_swallow;
   logic [31:0]             load_word;
   logic [31:0]             load_data;
   ms2ws_bus_t              payload;
   logic [MS2WS_BUS_WD-1:0] ms2ws_bus;

   // An excepting instruction never waits for memory
   assign cnt_zero       = (discard_cnt == '0);
   assign wait_mem       = mem_req_r & ~ex_r;
   assign data_ready     = ~wait_mem | rdata_buf_valid | (data_sram_data_ok & cnt_zero);
   assign ms_ready_go    = data_ready;
   assign es.ms_allowin  = ~ms_valid | (ms_ready_go & ws_allowin);
   assign ms2ws_valid    = ms_valid & ms_ready_go & ~wb_ex;
   assign ms_leave       = ms2ws_valid & ws_allowin;
   assign capture_rdata  = data_sram_data_ok & cnt_zero & ms_valid & wait_mem & ~rdata_buf_valid;
   assign inc_flushed_ms = wb_ex & ms_valid & wait_mem & ~data_ready;
   assign inc_flushed_es = wb_ex & es.es2ms_valid & es.es_mem_req;
   assign dec_swallow    = data_sram_data_ok & ~cnt_zero;

   // Next discard count: add cancelled requests, subtract swallowed responses, saturate
   always_comb begin
      cnt_sum = SUM_W'(discard_cnt) + SUM_W'(inc_flushed_ms) + SUM_W'(inc_flushed_es)
                - SUM_W'(dec_swallow);
      discard_cnt_next = cnt_sum[CNT_W-1:0];
      if (cnt_sum > SUM_W'(MAX_OUTSTANDING))
         discard_cnt_next = CNT_W'(MAX_OUTSTANDING);
   end

   // Stage occupancy; a flush empties the stage regardless of handshake
   always_ff @(posedge clk) begin
      if (!resetn)
         ms_valid <= 1'b0;
      else if (wb_ex)
         ms_valid <= 1'b0;
      else if (es.ms_allowin)
         ms_valid <= es.es2ms_valid;
   end

   // Latch the incoming instruction fields on an accepted handshake
   always_ff @(posedge clk) begin
      if (!resetn) begin
         pc_r           <= '0;
         mem_req_r      <= 1'b0;
         res_from_mem_r <= 1'b0;
         ld_op_r        <= '0;
         rf_we_r        <= 1'b0;
         rf_waddr_r     <= '0;
         result_r       <= '0;
         ex_r           <= 1'b0;
      end else if (es.es2ms_valid & es.ms_allowin) begin
         pc_r           <= es.es_pc;
         mem_req_r      <= es.es_mem_req;
         res_from_mem_r <= es.es_res_from_mem;
         ld_op_r        <= es.es_ld_op;
         rf_we_r        <= es.es_rf_we;
         rf_waddr_r     <= es.es_rf_waddr;
         result_r       <= es.es_result;
         ex_r           <= es.es_ex;
      end
   end

   // Hold the response word until the instruction leaves, so rdata is sampled once
   always_ff @(posedge clk) begin
      if (!resetn) begin
         rdata_buf_valid <= 1'b0;
         rdata_buf       <= '0;
      end else if (wb_ex | ms_leave) begin
         rdata_buf_valid <= 1'b0;
      end else if (capture_rdata) begin
         rdata_buf_valid <= 1'b1;
         rdata_buf       <= data_sram_rdata;
      end
   end

   // Count of responses still owed to cancelled requests
   always_ff @(posedge clk) begin
      if (!resetn)
         discard_cnt <= '0;
      else
         discard_cnt <= discard_cnt_next;
   end

   // More cancelled requests than the counter can track means lost bookkeeping
   assert property (@(posedge clk) disable iff (!resetn) cnt_sum <= SUM_W'(MAX_OUTSTANDING));

   assign load_word = rdata_buf_valid ? rdata_buf : data_sram_rdata;

   mem_load_align u_align (
      .w     (load_word),
      .a     (result_r[1:0]),
      .ld_op (ld_op_r),
      .data  (load_data)
   );

   assign payload.pc       = pc_r;
   assign payload.rf_we    = ms_valid & rf_we_r & ~ex_r;
   assign payload.rf_waddr = rf_waddr_r;
   assign payload.rf_wdata = res_from_mem_r ? load_data : result_r;
   assign payload.ex       = ms_valid & ex_r;
   assign ms2ws_bus        = payload;
   assign {ms_pc, ms_rf_we, ms_rf_waddr, ms_rf_wdata, ms_ex} = ms2ws_bus;

   // A load still waiting for data cannot be forwarded from this stage
   assign ms_fwd_blk = ms_valid & res_from_mem_r & ~data_ready;

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: table of single-instruction vectors, hand-written
// sequences for back-pressure, flush and reset, then randomized traffic
// against a transaction-level model of the stage.
module tb_mem_stage;

   localparam logic [4:0] OP_B  = 5'b10000;
   localparam logic [4:0] OP_BU = 5'b01000;
   localparam logic [4:0] OP_H  = 5'b00100;
   localparam logic [4:0] OP_HU = 5'b00010;
   localparam logic [4:0] OP_W  = 5'b00001;

   typedef struct {
      logic [4:0]  op;
      logic        load;
      logic        req;
      logic        ex;
      logic        rfWe;
      logic [31:0] result;
      logic [31:0] rdata;
      int          delay;
      logic [31:0] expWdata;
      logic        expWe;
      logic        expEx;
      int          expWaits;
      int          expBlk;
   } vec_t;

   logic        clk = 1'b0;
   logic        resetn;
   logic        data_sram_data_ok;
   logic [31:0] data_sram_rdata;
   logic        ws_allowin;
   logic        wb_ex;
   logic        ms2ws_valid;
   logic [31:0] ms_pc;
   logic        ms_rf_we;
   logic [4:0]  ms_rf_waddr;
   logic [31:0] ms_rf_wdata;
   logic        ms_ex;
   logic        ms_fwd_blk;

   int compared = 0;
   int mismatched = 0;

   mem_stage_if es ();

   mem_stage #(.MAX_OUTSTANDING(2)) dut (
      .clk               (clk),
      .resetn            (resetn),
      .es                (es),
      .data_sram_data_ok (data_sram_data_ok),
      .data_sram_rdata   (data_sram_rdata),
      .ws_allowin        (ws_allowin),
      .wb_ex             (wb_ex),
      .ms2ws_valid       (ms2ws_valid),
      .ms_pc             (ms_pc),
      .ms_rf_we          (ms_rf_we),
      .ms_rf_waddr       (ms_rf_waddr),
      .ms_rf_wdata       (ms_rf_wdata),
      .ms_ex             (ms_ex),
      .ms_fwd_blk        (ms_fwd_blk)
   );

   always #5 clk = ~clk;

   // Hard stop in case something wedges the run
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   function automatic logic [31:0] refLoad(input logic [31:0] w, input logic [1:0] a,
                                           input logic [4:0] op);
      logic [31:0] byteV;
      logic [31:0] halfV;
      byteV = (w >> (8 * a)) & 32'h0000_00FF;
      halfV = a[1] ? (w >> 16) : (w & 32'h0000_FFFF);
      case (op)
         OP_B:    return (byteV >= 32'd128) ? (byteV + 32'hFFFF_FF00) : byteV;
         OP_BU:   return byteV;
         OP_H:    return (halfV >= 32'd32768) ? (halfV + 32'hFFFF_0000) : halfV;
         OP_HU:   return halfV;
         default: return w;
      endcase
   endfunction

   function automatic vec_t mkVec(input logic [4:0] op, input logic load, input logic req,
                                  input logic ex, input logic rfWe, input logic [31:0] result,
                                  input logic [31:0] rdata, input int delay,
                                  input logic [31:0] expWdata, input logic expWe,
                                  input logic expEx, input int expWaits, input int expBlk);
      vec_t v;
      v.op = op; v.load = load; v.req = req; v.ex = ex; v.rfWe = rfWe;
      v.result = result; v.rdata = rdata; v.delay = delay;
      v.expWdata = expWdata; v.expWe = expWe; v.expEx = expEx;
      v.expWaits = expWaits; v.expBlk = expBlk;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic idleInputs();
      es.es2ms_valid     = 1'b0;
      es.es_pc           = '0;
      es.es_mem_req      = 1'b0;
      es.es_res_from_mem = 1'b0;
      es.es_ld_op        = '0;
      es.es_rf_we        = 1'b0;
      es.es_rf_waddr     = '0;
      es.es_result       = '0;
      es.es_ex           = 1'b0;
      data_sram_data_ok  = 1'b0;
      data_sram_rdata    = $urandom;
      ws_allowin         = 1'b1;
      wb_ex              = 1'b0;
   endtask

   task automatic driveInstr(input logic [31:0] pc, input logic [4:0] op, input logic load,
                             input logic req, input logic ex, input logic rfWe,
                             input logic [4:0] waddr, input logic [31:0] result);
      es.es2ms_valid     = 1'b1;
      es.es_pc           = pc;
      es.es_ld_op        = op;
      es.es_res_from_mem = load;
      es.es_mem_req      = req;
      es.es_ex           = ex;
      es.es_rf_we        = rfWe;
      es.es_rf_waddr     = waddr;
      es.es_result       = result;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   // Hand one instruction to an empty stage and follow it until it is handed off
   task automatic applyStimulus(input vec_t v, output logic [31:0] wdata, output logic we,
                                output logic ex, output int waits, output int blk,
                                output bit seen);
      driveInstr(32'h1C00_0000, v.op, v.load, v.req, v.ex, v.rfWe, 5'd7, v.result);
      ws_allowin = 1'b1;
      data_sram_data_ok = 1'b0;
      nextCycle();
      es.es2ms_valid = 1'b0;
      seen = 0; blk = 0; waits = 0; wdata = '0; we = 1'b0; ex = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         data_sram_data_ok = v.req && (k == v.delay);
         data_sram_rdata   = data_sram_data_ok ? v.rdata : $urandom;
         @(negedge clk);
         if (ms_fwd_blk) blk++;
         if (ms2ws_valid) begin
            seen = 1; waits = k; wdata = ms_rf_wdata; we = ms_rf_we; ex = ms_ex;
         end
         nextCycle();
      end
      data_sram_data_ok = 1'b0;
   endtask

   initial begin
      vec_t        vecs [13];
      logic [31:0] gotWdata;
      logic        gotWe;
      logic        gotEx;
      int          gotWaits;
      int          gotBlk;
      bit          gotSeen;
      int          handoffs;
      int          issued;
      // random-model state
      bit          occ, mReq, mGot, mLoad, mEx, mRfWe;
      logic [4:0]  mOp, mWaddr;
      logic [31:0] mPc, mResult, mResp;
      int          mCnt;
      bit          esV, ws, dOk, ready, expAllow, issueOk;
      int          kind;
      logic [31:0] nPc, nResult;
      logic [4:0]  nWaddr, nOp;
      bit          nRfWe, nLoad, nReq, nEx;

      vecs[0]  = mkVec(OP_W,  1, 1, 0, 1, 32'h0000_1000, 32'h8765_4321, 3, 32'h8765_4321, 1, 0, 3, 3);
      vecs[1]  = mkVec(OP_B,  1, 1, 0, 1, 32'h0000_1003, 32'h80FF_FF7F, 1, 32'hFFFF_FF80, 1, 0, 1, 1);
      vecs[2]  = mkVec(OP_BU, 1, 1, 0, 1, 32'h0000_1003, 32'h80FF_FF7F, 0, 32'h0000_0080, 1, 0, 0, 0);
      vecs[3]  = mkVec(OP_H,  1, 1, 0, 1, 32'h0000_1002, 32'h80FF_FF7F, 2, 32'hFFFF_80FF, 1, 0, 2, 2);
      vecs[4]  = mkVec(OP_HU, 1, 1, 0, 1, 32'h0000_1002, 32'h80FF_FF7F, 1, 32'h0000_80FF, 1, 0, 1, 1);
      vecs[5]  = mkVec(OP_B,  1, 1, 0, 1, 32'h0000_1000, 32'h80FF_FF7F, 0, 32'h0000_007F, 1, 0, 0, 0);
      vecs[6]  = mkVec(OP_BU, 1, 1, 0, 1, 32'h0000_1001, 32'h80FF_FF7F, 2, 32'h0000_00FF, 1, 0, 2, 2);
      vecs[7]  = mkVec(OP_H,  1, 1, 0, 1, 32'h0000_1000, 32'h80FF_FF7F, 1, 32'hFFFF_FF7F, 1, 0, 1, 1);
      vecs[8]  = mkVec(OP_HU, 1, 1, 0, 1, 32'h0000_1000, 32'h80FF_FF7F, 0, 32'h0000_FF7F, 1, 0, 0, 0);
      vecs[9]  = mkVec(5'b0,  0, 0, 0, 1, 32'h0000_0055, 32'h0,         0, 32'h0000_0055, 1, 0, 0, 0);
      vecs[10] = mkVec(5'b0,  0, 0, 1, 1, 32'h0000_0066, 32'h0,         0, 32'h0000_0066, 0, 1, 0, 0);
      vecs[11] = mkVec(5'b0,  0, 1, 0, 0, 32'h0000_2000, 32'h1111_2222, 2, 32'h0000_2000, 0, 0, 2, 0);
      vecs[12] = mkVec(5'b0,  0, 1, 1, 1, 32'h0000_0077, 32'h0,        99, 32'h0000_0077, 0, 1, 0, 0);

      // ---------------- reset ----------------
      idleInputs();
      resetn = 1'b0;
      nextCycle();
      nextCycle();
      @(negedge clk);
      checkOutput("reset_ms_allowin",  {31'b0, es.ms_allowin}, 32'd1);
      checkOutput("reset_ms2ws_valid", {31'b0, ms2ws_valid},   32'd0);
      checkOutput("reset_ms_pc",       ms_pc,                  32'd0);
      checkOutput("reset_ms_rf_we",    {31'b0, ms_rf_we},      32'd0);
      checkOutput("reset_ms_rf_waddr", {27'b0, ms_rf_waddr},   32'd0);
      checkOutput("reset_ms_rf_wdata", ms_rf_wdata,            32'd0);
      checkOutput("reset_ms_ex",       {31'b0, ms_ex},         32'd0);
      checkOutput("reset_ms_fwd_blk",  {31'b0, ms_fwd_blk},    32'd0);
      nextCycle();
      resetn = 1'b1;
      nextCycle();

      // ---------------- table-driven single instructions ----------------
      for (int i = 0; i < 13; i++) begin
         applyStimulus(vecs[i], gotWdata, gotWe, gotEx, gotWaits, gotBlk, gotSeen);
         checkOutput($sformatf("vec%0d_handoff", i), {31'b0, gotSeen}, 32'd1);
         checkOutput($sformatf("vec%0d_wdata", i),   gotWdata,         vecs[i].expWdata);
         checkOutput($sformatf("vec%0d_rf_we", i),   {31'b0, gotWe},   {31'b0, vecs[i].expWe});
         checkOutput($sformatf("vec%0d_ex", i),      {31'b0, gotEx},   {31'b0, vecs[i].expEx});
         checkOutput($sformatf("vec%0d_waits", i),   gotWaits,         vecs[i].expWaits);
         checkOutput($sformatf("vec%0d_fwd_blk", i), gotBlk,           vecs[i].expBlk);
      end

      // ---------------- response held across back-pressure ----------------
      handoffs = 0;
      driveInstr(32'h1C00_0100, OP_W, 1, 1, 0, 1, 5'd3, 32'h0000_4000);
      nextCycle();
      es.es2ms_valid = 1'b0;
      for (int k = 0; k < 8; k++) begin
         ws_allowin        = (k >= 5);
         data_sram_data_ok = (k == 1);
         data_sram_rdata   = (k == 1) ? 32'hCAFE_F00D : $urandom;
         @(negedge clk);
         if (ms2ws_valid && ws_allowin) handoffs++;
         if (k == 0) checkOutput("hold_blk_before_data", {31'b0, ms_fwd_blk}, 32'd1);
         if (k == 1) begin
            checkOutput("hold_valid_on_data",   {31'b0, ms2ws_valid},   32'd1);
            checkOutput("hold_allowin_blocked", {31'b0, es.ms_allowin}, 32'd0);
         end
         if (k == 4) checkOutput("hold_wdata_held",    ms_rf_wdata, 32'hCAFE_F00D);
         if (k == 5) checkOutput("hold_wdata_release", ms_rf_wdata, 32'hCAFE_F00D);
         nextCycle();
      end
      data_sram_data_ok = 1'b0;
      checkOutput("hold_single_handoff", handoffs, 32'd1);

      // ---------------- flush with pending request, stale response swallowed ----------------
      driveInstr(32'h1C00_0200, OP_W, 1, 1, 0, 1, 5'd4, 32'h0000_3000);
      nextCycle();
      es.es2ms_valid = 1'b0;
      @(negedge clk);
      checkOutput("flush_blk_pending", {31'b0, ms_fwd_blk}, 32'd1);
      nextCycle();
      wb_ex = 1'b1;
      @(negedge clk);
      checkOutput("flush_no_handoff", {31'b0, ms2ws_valid}, 32'd0);
      nextCycle();
      wb_ex = 1'b0;
      @(negedge clk);
      checkOutput("flush_stage_empty", {31'b0, es.ms_allowin}, 32'd1);
      checkOutput("flush_rf_we_off",   {31'b0, ms_rf_we},      32'd0);
      nextCycle();
      driveInstr(32'h1C00_0204, OP_W, 1, 1, 0, 1, 5'd5, 32'h0000_3004);
      nextCycle();
      es.es2ms_valid = 1'b0;
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = 32'h0000_DEAD;
      @(negedge clk);
      checkOutput("swallow_no_valid", {31'b0, ms2ws_valid}, 32'd0);
      checkOutput("swallow_blk",      {31'b0, ms_fwd_blk},  32'd1);
      nextCycle();
      data_sram_data_ok = 1'b0;
      data_sram_rdata   = $urandom;
      @(negedge clk);
      checkOutput("swallow_not_captured", {31'b0, ms_fwd_blk}, 32'd1);
      nextCycle();
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = 32'h0000_1234;
      @(negedge clk);
      checkOutput("swallow_second_valid", {31'b0, ms2ws_valid}, 32'd1);
      checkOutput("swallow_second_wdata", ms_rf_wdata,          32'h0000_1234);
      nextCycle();
      data_sram_data_ok = 1'b0;

      // ---------------- flush coinciding with the response ----------------
      driveInstr(32'h1C00_0300, OP_W, 1, 1, 0, 1, 5'd6, 32'h0000_5000);
      nextCycle();
      es.es2ms_valid = 1'b0;
      nextCycle();
      wb_ex = 1'b1;
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = 32'h0000_0BAD;
      @(negedge clk);
      checkOutput("flushok_no_handoff", {31'b0, ms2ws_valid}, 32'd0);
      nextCycle();
      wb_ex = 1'b0;
      data_sram_data_ok = 1'b0;
      nextCycle();
      driveInstr(32'h1C00_0304, OP_W, 1, 1, 0, 1, 5'd6, 32'h0000_5004);
      nextCycle();
      es.es2ms_valid = 1'b0;
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = 32'h00C0_FFEE;
      @(negedge clk);
      checkOutput("flushok_next_valid", {31'b0, ms2ws_valid}, 32'd1);
      checkOutput("flushok_next_wdata", ms_rf_wdata,          32'h00C0_FFEE);
      nextCycle();
      data_sram_data_ok = 1'b0;

      // ---------------- eight ALU instructions back to back ----------------
      for (int i = 0; i < 9; i++) begin
         if (i < 8)
            driveInstr(32'h0000_2000 + 32'(4 * i), 5'b0, 0, 0, 0, 1, 5'(i), 32'(i));
         else
            es.es2ms_valid = 1'b0;
         ws_allowin = 1'b1;
         @(negedge clk);
         checkOutput($sformatf("b2b%0d_allowin", i), {31'b0, es.ms_allowin}, 32'd1);
         if (i >= 1) begin
            checkOutput($sformatf("b2b%0d_valid", i), {31'b0, ms2ws_valid}, 32'd1);
            checkOutput($sformatf("b2b%0d_pc", i),    ms_pc, 32'h0000_2000 + 32'(4 * (i - 1)));
         end
         nextCycle();
      end
      es.es2ms_valid = 1'b0;

      // ---------------- reset in the middle of a load ----------------
      driveInstr(32'h1C00_0400, OP_W, 1, 1, 0, 1, 5'd9, 32'h0000_6000);
      nextCycle();
      es.es2ms_valid = 1'b0;
      nextCycle();
      resetn = 1'b0;
      nextCycle();
      resetn = 1'b1;
      @(negedge clk);
      checkOutput("midrst_allowin", {31'b0, es.ms_allowin}, 32'd1);
      checkOutput("midrst_valid",   {31'b0, ms2ws_valid},   32'd0);
      checkOutput("midrst_pc",      ms_pc,                  32'd0);
      checkOutput("midrst_blk",     {31'b0, ms_fwd_blk},    32'd0);
      nextCycle();
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = 32'h0000_0BAD;
      @(negedge clk);
      checkOutput("midrst_late_ok_ignored", {31'b0, ms2ws_valid}, 32'd0);
      nextCycle();
      data_sram_data_ok = 1'b0;
      applyStimulus(vecs[0], gotWdata, gotWe, gotEx, gotWaits, gotBlk, gotSeen);
      checkOutput("midrst_after_wdata", gotWdata, 32'h8765_4321);
      checkOutput("midrst_after_waits", gotWaits, 32'd3);

      // ---------------- randomized traffic against the transaction model ----------------
      occ = 0; mReq = 0; mGot = 0; mLoad = 0; mEx = 0; mRfWe = 0;
      mOp = '0; mWaddr = '0; mPc = '0; mResult = '0; mResp = '0; mCnt = 0;
      handoffs = 0; issued = 0;
      for (int cyc = 0; cyc < 420; cyc++) begin
         issueOk = (cyc < 400);
         esV     = issueOk && ($urandom_range(0, 9) < 7);
         kind    = $urandom_range(0, 3);
         nPc     = $urandom;
         nResult = $urandom;
         nWaddr  = 5'($urandom);
         nRfWe   = 1'($urandom);
         nOp     = 5'b00001 << $urandom_range(0, 4);
         nLoad   = (kind == 1);
         nReq    = (kind == 1) || (kind == 2);
         nEx     = (kind == 3);
         driveInstr(nPc, nLoad ? nOp : 5'b0, nLoad, nReq, nEx, nRfWe, nWaddr, nResult);
         es.es2ms_valid = esV;
         ws  = issueOk ? ($urandom_range(0, 9) < 6) : 1'b1;
         ws_allowin = ws;
         dOk = occ && mReq && !mGot && (mCnt == 0);
         data_sram_data_ok = dOk;
         data_sram_rdata   = dOk ? mResp : $urandom;
         @(negedge clk);
         ready    = occ && (!mReq || mGot || dOk);
         expAllow = !occ || (ready && ws);
         checkOutput("rnd_ms2ws_valid", {31'b0, ms2ws_valid},   {31'b0, ready});
         checkOutput("rnd_ms_allowin",  {31'b0, es.ms_allowin}, {31'b0, expAllow});
         checkOutput("rnd_fwd_blk",     {31'b0, ms_fwd_blk},    {31'b0, occ && mLoad && !ready});
         if (ready && ws) begin
            checkOutput("rnd_pc",       ms_pc,                 mPc);
            checkOutput("rnd_rf_we",    {31'b0, ms_rf_we},     {31'b0, mRfWe && !mEx});
            checkOutput("rnd_rf_waddr", {27'b0, ms_rf_waddr},  {27'b0, mWaddr});
            checkOutput("rnd_ex",       {31'b0, ms_ex},        {31'b0, mEx});
            if (!mEx)
               checkOutput("rnd_wdata", ms_rf_wdata,
                           mLoad ? refLoad(mResp, mResult[1:0], mOp) : mResult);
         end
         nextCycle();
         if (dOk)
            mGot = 1;
         else if (occ && mReq && !mGot && mCnt > 0)
            mCnt--;
         if (ready && ws) begin
            occ = 0;
            handoffs++;
         end
         if (esV && expAllow) begin
            occ = 1; mPc = nPc; mOp = nOp; mLoad = nLoad; mReq = nReq; mEx = nEx;
            mRfWe = nRfWe; mWaddr = nWaddr; mResult = nResult;
            mGot = 0; mCnt = $urandom_range(0, 4); mResp = $urandom;
            issued++;
         end
      end
      idleInputs();
      checkOutput("rnd_all_delivered", handoffs, issued);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
